// File: rtl/pif_boot_rom_loader.sv
// Boot ROM for the PIF CPU: a host streams the image in once after reset, then
// the array write-locks and serves pipelined reads with 1 or 2 cycles of latency.
module pif_boot_rom_loader #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  locked,
    input  logic [ADDR_WIDTH-1:0] address_a,
    input  logic                  oe,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  read_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_en_c;
    logic                    last_wr_c;
    logic                    rd_accept_c;
    logic                    rd_reject_c;
    logic                    in_range_c;

    logic                    rd_valid1;
    logic                    rd_err1;
    logic [DATA_WIDTH-1:0]   rd_data1;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_start) state_next = LOADING;
            LOADING: if (load_valid && (ptr == LAST_ADDR)) state_next = LOCKED;
            LOCKED:  state_next = LOCKED;
            default: state_next = IDLE;
        endcase
    end

    // Write strobes and read accept/reject decode; reads only succeed once locked.
    always_comb begin
        wr_en_c     = 1'b0;
        last_wr_c   = 1'b0;
        rd_accept_c = 1'b0;
        rd_reject_c = 1'b0;
        in_range_c  = (32'(address_a) < DEPTH);
        case (state)
            LOADING: begin
                wr_en_c     = load_valid;
                last_wr_c   = load_valid && (ptr == LAST_ADDR);
                rd_reject_c = oe;
            end
            LOCKED:  rd_accept_c = oe;
            default: rd_reject_c = oe;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            locked     <= 1'b0;
        end else begin
            load_ready <= (state_next == LOADING);
            load_done  <= last_wr_c;
            locked     <= (state_next == LOCKED);
            if ((state == IDLE) && load_start)
                ptr <= '0;
            else if (wr_en_c && !last_wr_c)
                ptr <= ptr + ADDR_WIDTH'(1);
        end
    end

    // Image storage is never reset; reset only blocks a write in its own cycle.
    always_ff @(posedge clk) begin
        if (wr_en_c && !reset)
            mem[ptr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid1 <= 1'b0;
            rd_err1   <= 1'b0;
            rd_data1  <= '0;
        end else begin
            rd_valid1 <= rd_accept_c;
            rd_err1   <= rd_reject_c;
            if (rd_accept_c)
                rd_data1 <= in_range_c ? mem[address_a] : '0;
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid    <= 1'b0;
                    read_err <= 1'b0;
                    q_a      <= '0;
                end else begin
                    valid    <= rd_valid1;
                    read_err <= rd_err1;
                    if (rd_valid1)
                        q_a <= rd_data1;
                end
            end
        end else begin : g_lat1
            assign valid    = rd_valid1;
            assign read_err = rd_err1;
            assign q_a      = rd_data1;
        end
    endgenerate

endmodule
